// File: rtl/pulse_burst_pkg.sv
// Shared constants for the pulse burst generator: default widths and state encodings.
package pulse_burst_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam int unsigned TIM_W_DEFAULT = 16;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHigh = 2'd1;
  localparam logic [1:0] StLow  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

endpackage

// File: rtl/state_timer.sv
// Saturating cycles-in-state counter; clr zeroes it on the edge where the state changes.
module state_timer #(
  parameter int unsigned TIM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [TIM_W-1:0] t
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t <= '0;
    end else if (clr) begin
      t <= '0;
    end else if (t != '1) begin
      t <= t + TIM_W'(1);
    end
  end

endmodule

// File: rtl/pulse_burst_fsm.sv
// Emits a burst of burst_len pulses with programmable high/low phase lengths.
module pulse_burst_fsm
  import pulse_burst_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned TIM_W = TIM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [TIM_W-1:0] high_t,
  input  logic [TIM_W-1:0] low_t,
  output logic             pulse,
  output logic             pulse_reg,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] r_cnt, r_cnt_next;
  logic [TIM_W-1:0] r_high, r_high_next;
  logic [TIM_W-1:0] r_low, r_low_next;
  logic [TIM_W-1:0] t;

  state_timer #(
    .TIM_W (TIM_W)
  ) u_state_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_next != state_reg),
    .t     (t)
  );

  always_comb begin
    state_next  = state_reg;
    r_cnt_next  = r_cnt;
    r_high_next = r_high;
    r_low_next  = r_low;
    pulse       = 1'b0;
    unique case (state_reg)
      StIdle: begin
        if (start) begin
          if (burst_len != '0) begin
            state_next  = StHigh;
            r_cnt_next  = burst_len;
            // Zero-length phases are stretched to one cycle.
            r_high_next = (high_t == '0) ? TIM_W'(1) : high_t;
            r_low_next  = (low_t == '0) ? TIM_W'(1) : low_t;
          end else begin
            state_next = StDone;
          end
        end
      end
      StHigh: begin
        if (abort) begin
          r_cnt_next = '0;
          state_next = StDone;
        end else begin
          pulse = 1'b1;
          if (t >= r_high - TIM_W'(1)) begin
            r_cnt_next = r_cnt - CNT_W'(1);
            state_next = (r_cnt == CNT_W'(1)) ? StDone : StLow;
          end
        end
      end
      StLow: begin
        if (abort) begin
          r_cnt_next = '0;
          state_next = StDone;
        end else if (t >= r_low - TIM_W'(1)) begin
          state_next = StHigh;
        end
      end
      StDone: begin
        r_cnt_next = '0;
        state_next = StIdle;
      end
      default: state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= StIdle;
      r_cnt     <= '0;
      r_high    <= TIM_W'(1);
      r_low     <= TIM_W'(1);
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_cnt     <= r_cnt_next;
      r_high    <= r_high_next;
      r_low     <= r_low_next;
      pulse_reg <= pulse;
    end
  end

  assign busy        = (state_reg == StHigh) || (state_reg == StLow);
  assign done        = (state_reg == StDone);
  assign pulses_left = r_cnt;

endmodule

// File: tb/tb_pulse_burst_fsm.sv
// Randomized bench: per-burst expected waveforms are built from the burst rules and compared cycle by cycle.
module tb_pulse_burst_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  burst_len;
  logic [15:0] high_t;
  logic [15:0] low_t;
  logic        pulse;
  logic        pulse_reg;
  logic        busy;
  logic        done;
  logic [7:0]  pulses_left;

  typedef struct {
    bit p;
    bit b;
    bit d;
    int pl;
  } exp_t;

  int checks = 0;
  int errors = 0;
  bit prev_pulse = 1'b0;

  pulse_burst_fsm #(
    .CNT_W (8),
    .TIM_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .burst_len   (burst_len),
    .high_t      (high_t),
    .low_t       (low_t),
    .pulse       (pulse),
    .pulse_reg   (pulse_reg),
    .busy        (busy),
    .done        (done),
    .pulses_left (pulses_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t mk(input bit p, input bit b, input bit d, input int pl);
    exp_t e;
    e.p  = p;
    e.b  = b;
    e.d  = d;
    e.pl = pl;
    return e;
  endfunction

  task automatic check_outputs(input exp_t e);
    check("pulse", int'(pulse), int'(e.p));
    check("pulse_reg", int'(pulse_reg), int'(prev_pulse));
    check("busy", int'(busy), int'(e.b));
    check("done", int'(done), int'(e.d));
    check("pulses_left", int'(pulses_left), e.pl);
    prev_pulse = e.p;
  endtask

  task automatic step(input exp_t e, input logic st, input logic ab, input logic [7:0] bl,
                      input logic [15:0] ht, input logic [15:0] lt);
    @(negedge clk);
    start     = st;
    abort     = ab;
    burst_len = bl;
    high_t    = ht;
    low_t     = lt;
    #1;
    check_outputs(e);
  endtask

  // abort_at indexes the busy cycles of the burst (-1 = no abort); glitch re-requests while busy.
  task automatic run_burst(input int len, input int h, input int l, input int abort_at,
                           input bit glitch);
    exp_t bq[$];
    int   eh = (h == 0) ? 1 : h;
    int   el = (l == 0) ? 1 : l;
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < eh; c++) bq.push_back(mk(1'b1, 1'b1, 1'b0, len - i));
      if (i < len - 1) begin
        for (int c = 0; c < el; c++) bq.push_back(mk(1'b0, 1'b1, 1'b0, len - i - 1));
      end
    end
    if (abort_at >= 0 && abort_at < bq.size()) begin
      while (bq.size() > abort_at + 1) void'(bq.pop_back());
      bq[abort_at].p = 1'b0;
    end
    step(mk(1'b0, 1'b0, 1'b0, 0), 1'b1, 1'($urandom), 8'(len), 16'(h), 16'(l));
    for (int j = 0; j < bq.size(); j++) begin
      step(bq[j], glitch && (j == 1), 1'(j == abort_at), 8'($urandom_range(1, 9)),
           16'($urandom_range(0, 5)), 16'($urandom_range(0, 5)));
    end
    step(mk(1'b0, 1'b0, 1'b1, 0), 1'b0, 1'($urandom), 8'(len), 16'(h), 16'(l));
    step(mk(1'b0, 1'b0, 1'b0, 0), 1'b0, 1'($urandom), 8'(len), 16'(h), 16'(l));
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    burst_len = '0;
    high_t    = '0;
    low_t     = '0;
    #1;
    check_outputs(mk(1'b0, 1'b0, 1'b0, 0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_burst(3, 2, 3, -1, 1'b0);
    run_burst(0, 2, 2, -1, 1'b0);
    run_burst(2, 0, 0, -1, 1'b0);
    run_burst(5, 4, 2, 7, 1'b0);
    run_burst(2, 1, 2, -1, 1'b1);
    run_burst(1, 3, 3, 0, 1'b0);

    // Reset in the first LOW cycle, while pulse_reg still holds the last high.
    run_burst(0, 0, 0, -1, 1'b0);
    step(mk(1'b0, 1'b0, 1'b0, 0), 1'b1, 1'b0, 8'd3, 16'd2, 16'd3);
    step(mk(1'b1, 1'b1, 1'b0, 3), 1'b0, 1'b0, 8'd3, 16'd2, 16'd3);
    step(mk(1'b1, 1'b1, 1'b0, 3), 1'b0, 1'b0, 8'd3, 16'd2, 16'd3);
    step(mk(1'b0, 1'b1, 1'b0, 2), 1'b0, 1'b0, 8'd3, 16'd2, 16'd3);
    reset = 1'b1;
    #1;
    prev_pulse = 1'b0;
    check_outputs(mk(1'b0, 1'b0, 1'b0, 0));
    @(negedge clk);
    #1;
    check_outputs(mk(1'b0, 1'b0, 1'b0, 0));
    reset = 1'b0;
    run_burst(3, 2, 3, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int len = $urandom_range(0, 4);
      int h   = $urandom_range(0, 3);
      int l   = $urandom_range(0, 3);
      int ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 12) : -1;
      run_burst(len, h, l, ab, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
